// File: rtl/axi_dma_master_if.sv
// AXI4 channel bundle (AW/W/B/AR/R) between axi_dma_master and its memory side.
interface axi_dma_master_if #(
  parameter int ID_WD   = 2,
  parameter int DATA_WD = 32,
  parameter int ADDR_WD = 32,
  parameter int STRB_WD = DATA_WD / 8
);
  logic [ADDR_WD-1:0] AWADDR;
  logic [ID_WD-1:0]   AWID;
  logic [1:0]         AWBURST;
  logic [2:0]         AWSIZE;
  logic [7:0]         AWLEN;
  logic               AWVALID;
  logic               AWREADY;

  logic [DATA_WD-1:0] WDATA;
  logic [STRB_WD-1:0] WSTRB;
  logic               WLAST;
  logic               WVALID;
  logic               WREADY;

  logic [ID_WD-1:0]   BID;
  logic [1:0]         BRESP;
  logic               BVALID;
  logic               BREADY;

  logic [ADDR_WD-1:0] ARADDR;
  logic [ID_WD-1:0]   ARID;
  logic [1:0]         ARBURST;
  logic [2:0]         ARSIZE;
  logic [7:0]         ARLEN;
  logic               ARVALID;
  logic               ARREADY;

  logic [DATA_WD-1:0] RDATA;
  logic               RLAST;
  logic [ID_WD-1:0]   RID;
  logic [1:0]         RRESP;
  logic               RVALID;
  logic               RREADY;

  modport master (
    output AWADDR, AWID, AWBURST, AWSIZE, AWLEN, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input BID, BRESP, BVALID, output BREADY,
    output ARADDR, ARID, ARBURST, ARSIZE, ARLEN, ARVALID, input ARREADY,
    input RDATA, RLAST, RID, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWID, AWBURST, AWSIZE, AWLEN, AWVALID, output AWREADY,
    input WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input ARADDR, ARID, ARBURST, ARSIZE, ARLEN, ARVALID, output ARREADY,
    output RDATA, RLAST, RID, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/axi_dma_master.sv
// AXI4 copy engine: per chunk one INCR read burst into a local buffer, then one INCR write burst; one burst outstanding, every channel stalls on VALID/READY.
// AXI_DMA_RESP_CHECK_EN: nonzero RRESP/BRESP sets o_err and ends the transfer once the current burst completes.
module axi_dma_master #(
  parameter int AXI_ID_WD   = 2,
  parameter int AXI_DATA_WD = 32,
  parameter int AXI_ADDR_WD = 32,
  parameter int AXI_STRB_WD = AXI_DATA_WD / 8,
  parameter int MAX_BURST   = 16,
  parameter int LEN_WD      = 16
) (
  input  logic                   M_AXI_ACLK,
  input  logic                   M_AXI_ARESET,
  input  logic                   i_start,
  input  logic [AXI_ADDR_WD-1:0] i_src_addr,
  input  logic [AXI_ADDR_WD-1:0] i_dst_addr,
  input  logic [LEN_WD-1:0]      i_num_beats,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  axi_dma_master_if.master       m_axi
);
  localparam int SZ       = $clog2(AXI_STRB_WD);
  localparam int BEATS_4K = 4096 / AXI_STRB_WD;
  localparam int BW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [AXI_ADDR_WD-1:0] ALIGN_MASK = {{(AXI_ADDR_WD-SZ){1'b1}}, {SZ{1'b0}}};

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP} state_t;

  state_t                 state_q;
  logic [AXI_ADDR_WD-1:0] src_q, dst_q;
  logic [LEN_WD-1:0]      remaining_q;
  logic [BW-1:0]          beat_cnt_q;
  logic                   arvalid_q, rready_q, awvalid_q, wvalid_q, wlast_q, bready_q;
  logic                   busy_q, done_q, err_q;
  logic [AXI_DATA_WD-1:0] data_buf_q [MAX_BURST];

  logic [31:0]            src_room, dst_room, chunk_w;
  logic [8:0]             chunk_n, chunk_last, beat_w;
  logic [AXI_ADDR_WD-1:0] step;
  logic                   rd_err, wr_err;

  // Chunk size clipped by remaining count, buffer depth and both 4KB pages.
  always_comb begin
    src_room = 32'(BEATS_4K) - 32'(src_q[11:SZ]);
    dst_room = 32'(BEATS_4K) - 32'(dst_q[11:SZ]);
    chunk_w  = 32'(remaining_q);
    if (32'(MAX_BURST) < chunk_w) chunk_w = 32'(MAX_BURST);
    if (src_room < chunk_w)       chunk_w = src_room;
    if (dst_room < chunk_w)       chunk_w = dst_room;
  end

  assign chunk_n    = chunk_w[8:0];
  assign chunk_last = chunk_n - 9'd1;
  assign beat_w     = 9'(beat_cnt_q);
  assign step       = AXI_ADDR_WD'(chunk_n) << SZ;

`ifdef AXI_DMA_RESP_CHECK_EN
  assign rd_err = (m_axi.RRESP != 2'b00);
  assign wr_err = (m_axi.BRESP != 2'b00);
`else
  assign rd_err = 1'b0;
  assign wr_err = 1'b0;
`endif

  logic unused_sig;
  assign unused_sig = ^{m_axi.RID, m_axi.BID, m_axi.RLAST, m_axi.RRESP, m_axi.BRESP,
                        chunk_w[31:9], chunk_last[8]};

  assign m_axi.ARADDR  = src_q;
  assign m_axi.ARID    = '0;
  assign m_axi.ARBURST = 2'b01;
  assign m_axi.ARSIZE  = 3'(SZ);
  assign m_axi.ARLEN   = chunk_last[7:0];
  assign m_axi.ARVALID = arvalid_q;
  assign m_axi.RREADY  = rready_q;
  assign m_axi.AWADDR  = dst_q;
  assign m_axi.AWID    = '0;
  assign m_axi.AWBURST = 2'b01;
  assign m_axi.AWSIZE  = 3'(SZ);
  assign m_axi.AWLEN   = chunk_last[7:0];
  assign m_axi.AWVALID = awvalid_q;
  assign m_axi.WDATA   = data_buf_q[beat_cnt_q];
  assign m_axi.WSTRB   = '1;
  assign m_axi.WLAST   = wlast_q;
  assign m_axi.WVALID  = wvalid_q;
  assign m_axi.BREADY  = bready_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err         = err_q;

  always_ff @(posedge M_AXI_ACLK) begin
    if (rready_q && m_axi.RVALID) data_buf_q[beat_cnt_q] <= m_axi.RDATA;
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            err_q <= 1'b0;
            if (i_num_beats != '0) begin
              src_q       <= i_src_addr & ALIGN_MASK;
              dst_q       <= i_dst_addr & ALIGN_MASK;
              remaining_q <= i_num_beats;
              busy_q      <= 1'b1;
              arvalid_q   <= 1'b1;
              state_q     <= RD_ADDR;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (m_axi.ARREADY) begin
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b1;
            beat_cnt_q <= '0;
            state_q    <= RD_DATA;
          end
        end
        RD_DATA: begin
          // The beat count, not RLAST, closes the read burst.
          if (m_axi.RVALID) begin
            if (rd_err) err_q <= 1'b1;
            if (beat_w == chunk_last) begin
              rready_q   <= 1'b0;
              beat_cnt_q <= '0;
              if (err_q || rd_err) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                awvalid_q <= 1'b1;
                state_q   <= WR_ADDR;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + BW'(1);
            end
          end
        end
        WR_ADDR: begin
          if (m_axi.AWREADY) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= (chunk_last == 9'd0);
            state_q   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (m_axi.WREADY) begin
            if (wlast_q) begin
              wvalid_q   <= 1'b0;
              wlast_q    <= 1'b0;
              bready_q   <= 1'b1;
              beat_cnt_q <= '0;
              state_q    <= WR_RESP;
            end else begin
              beat_cnt_q <= beat_cnt_q + BW'(1);
              wlast_q    <= ((beat_w + 9'd1) == chunk_last);
            end
          end
        end
        WR_RESP: begin
          if (m_axi.BVALID) begin
            bready_q    <= 1'b0;
            src_q       <= src_q + step;
            dst_q       <= dst_q + step;
            remaining_q <= remaining_q - LEN_WD'(chunk_n);
            if (wr_err) err_q <= 1'b1;
            if ((remaining_q == LEN_WD'(chunk_n)) || wr_err) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_ADDR;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_dma_master.sv
// Directed bench for axi_dma_master: word-addressed slave memory with optional random stalls, burst logs and hand-computed expectations.
module tb_axi_dma_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_a, dst_a;
  logic [15:0] nb;
  logic        busy, done, err;

  axi_dma_master_if #(.ID_WD(2), .DATA_WD(32), .ADDR_WD(32), .STRB_WD(4)) axi ();

  axi_dma_master #(
    .AXI_ID_WD(2), .AXI_DATA_WD(32), .AXI_ADDR_WD(32), .AXI_STRB_WD(4),
    .MAX_BURST(16), .LEN_WD(16)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .i_start(start),
    .i_src_addr(src_a), .i_dst_addr(dst_a), .i_num_beats(nb),
    .o_busy(busy), .o_done(done), .o_err(err), .m_axi(axi)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] mem [4096];
  logic [31:0] ref_mem [4096];

  function automatic int widx(input logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  // Slave state and logs
  bit          bp_en = 1'b0;
  int          bresp_err_idx = -1;
  bit          rd_active, r_fired, aw_open, b_pend, b_fired;
  int          r_beat, w_beat, ar_len_c, aw_len_c;
  logic [31:0] ar_addr_c, aw_addr_c;
  int          b_cnt, b_idx, done_cnt;
  logic [31:0] ar_log_addr[$], aw_log_addr[$];
  int          ar_log_len[$], aw_log_len[$];
  bit          ar_stall, aw_stall, w_stall;
  logic [31:0] ar_p_addr, aw_p_addr, w_p_dat;
  logic [7:0]  ar_p_len, aw_p_len;
  logic        w_p_last;

  // All slave activity happens on the falling edge; a handshake is decided here and lands on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      rd_active = 0; r_fired = 0; aw_open = 0; b_pend = 0; b_fired = 0;
      ar_stall = 0; aw_stall = 0; w_stall = 0;
      axi.ARREADY = 0; axi.AWREADY = 0; axi.WREADY = 0;
      axi.RVALID = 0; axi.RDATA = 0; axi.RLAST = 0; axi.RID = 0; axi.RRESP = 0;
      axi.BVALID = 0; axi.BID = 0; axi.BRESP = 0;
    end else begin
      if (done) done_cnt++;
      if (ar_stall) begin
        check("ar_hold_valid", 32'(axi.ARVALID), 32'd1);
        check("ar_hold_addr", axi.ARADDR, ar_p_addr);
        check("ar_hold_len", 32'(axi.ARLEN), 32'(ar_p_len));
      end
      if (aw_stall) begin
        check("aw_hold_valid", 32'(axi.AWVALID), 32'd1);
        check("aw_hold_addr", axi.AWADDR, aw_p_addr);
        check("aw_hold_len", 32'(axi.AWLEN), 32'(aw_p_len));
      end
      if (w_stall) begin
        check("w_hold_valid", 32'(axi.WVALID), 32'd1);
        check("w_hold_data", axi.WDATA, w_p_dat);
        check("w_hold_last", 32'(axi.WLAST), 32'(w_p_last));
      end
      // R
      if (r_fired) begin
        r_fired = 0; axi.RVALID = 0; r_beat++;
        if (r_beat > ar_len_c) rd_active = 0;
      end
      if (rd_active && !axi.RVALID && (!bp_en || $urandom_range(0, 2) != 0)) begin
        axi.RVALID = 1;
        axi.RDATA  = mem[widx(ar_addr_c) + r_beat];
        axi.RLAST  = (r_beat == ar_len_c);
      end
      r_fired = axi.RVALID && axi.RREADY;
      // AR
      axi.ARREADY = !rd_active && (!bp_en || $urandom_range(0, 2) == 0);
      if (axi.ARVALID && axi.ARREADY) begin
        ar_addr_c = axi.ARADDR; ar_len_c = int'(axi.ARLEN);
        ar_log_addr.push_back(axi.ARADDR); ar_log_len.push_back(int'(axi.ARLEN));
        check("arburst", 32'(axi.ARBURST), 32'd1);
        check("arsize", 32'(axi.ARSIZE), 32'd2);
        rd_active = 1; r_beat = 0;
      end
      // B before W so BVALID never precedes the last W handshake
      if (b_fired) begin b_fired = 0; axi.BVALID = 0; end
      if (b_pend && !axi.BVALID && (!bp_en || $urandom_range(0, 2) != 0)) begin
        axi.BVALID = 1;
        axi.BRESP  = (b_idx == bresp_err_idx) ? 2'b10 : 2'b00;
      end
      if (axi.BVALID && axi.BREADY) begin
        b_fired = 1; b_pend = 0; b_cnt++; b_idx++;
      end
      // W
      axi.WREADY = !bp_en || $urandom_range(0, 2) != 0;
      if (axi.WVALID) check("w_after_aw", 32'(aw_open), 32'd1);
      if (axi.WVALID && axi.WREADY) begin
        mem[widx(aw_addr_c) + w_beat] = axi.WDATA;
        check("wlast", 32'(axi.WLAST), 32'(w_beat == aw_len_c));
        check("wstrb", 32'(axi.WSTRB), 32'hF);
        if (axi.WLAST) begin aw_open = 0; b_pend = 1; end
        w_beat++;
      end
      // AW
      axi.AWREADY = !aw_open && !b_pend && (!bp_en || $urandom_range(0, 2) == 0);
      if (axi.AWVALID && axi.AWREADY) begin
        aw_addr_c = axi.AWADDR; aw_len_c = int'(axi.AWLEN);
        aw_log_addr.push_back(axi.AWADDR); aw_log_len.push_back(int'(axi.AWLEN));
        check("awburst", 32'(axi.AWBURST), 32'd1);
        check("awsize", 32'(axi.AWSIZE), 32'd2);
        aw_open = 1; w_beat = 0;
      end
      ar_stall = axi.ARVALID && !axi.ARREADY; ar_p_addr = axi.ARADDR; ar_p_len = axi.ARLEN;
      aw_stall = axi.AWVALID && !axi.AWREADY; aw_p_addr = axi.AWADDR; aw_p_len = axi.AWLEN;
      w_stall  = axi.WVALID && !axi.WREADY;   w_p_dat = axi.WDATA;    w_p_last = axi.WLAST;
    end
  end

  logic [31:0] exp_ar [4];
  logic [31:0] exp_aw [4];
  int          exp_len [4];

  task automatic start_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    ar_log_addr.delete(); ar_log_len.delete(); aw_log_addr.delete(); aw_log_len.delete();
    b_cnt = 0; b_idx = 0; done_cnt = 0;
    src_a = s; dst_a = d; nb = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_bursts(input string tag, input int n);
    check({tag, "_ar_cnt"}, 32'(ar_log_addr.size()), 32'(n));
    check({tag, "_aw_cnt"}, 32'(aw_log_addr.size()), 32'(n));
    check({tag, "_b_cnt"}, 32'(b_cnt), 32'(n));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    for (int i = 0; i < ar_log_addr.size(); i++) begin
      check($sformatf("%s_ar%0d_addr", tag, i), ar_log_addr[i], exp_ar[i]);
      check($sformatf("%s_ar%0d_len", tag, i), 32'(ar_log_len[i]), 32'(exp_len[i]));
    end
    for (int i = 0; i < aw_log_addr.size(); i++) begin
      check($sformatf("%s_aw%0d_addr", tag, i), aw_log_addr[i], exp_aw[i]);
      check($sformatf("%s_aw%0d_len", tag, i), 32'(aw_log_len[i]), 32'(exp_len[i]));
    end
  endtask

  task automatic check_copy(input string tag, input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_data%0d", tag, i), mem[widx(d) + i], ref_mem[widx(s) + i]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src_a = '0; dst_a = '0; nb = '0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 32'hC0DE0000 ^ (32'(i) * 32'h00010007);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    check("rst_arvalid", 32'(axi.ARVALID), 32'd0);
    check("rst_awvalid", 32'(axi.AWVALID), 32'd0);
    check("rst_wvalid", 32'(axi.WVALID), 32'd0);
    check("rst_rready", 32'(axi.RREADY), 32'd0);
    check("rst_bready", 32'(axi.BREADY), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single 4-beat chunk
    start_cmd(32'h000, 32'h100, 16'd4);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done("t1");
    repeat (3) @(negedge clk);
    exp_ar = '{32'h000, 32'h0, 32'h0, 32'h0}; exp_aw = '{32'h100, 32'h0, 32'h0, 32'h0};
    exp_len = '{3, 0, 0, 0};
    check_bursts("t1", 1);
    check_copy("t1", 32'h000, 32'h100, 4);

    // 40 beats split by buffer depth
    start_cmd(32'h400, 32'h800, 16'd40);
    wait_done("t2");
    check("t2_b_before_done", 32'(b_cnt), 32'd3);
    repeat (3) @(negedge clk);
    exp_ar = '{32'h400, 32'h440, 32'h480, 32'h0}; exp_aw = '{32'h800, 32'h840, 32'h880, 32'h0};
    exp_len = '{15, 15, 7, 0};
    check_bursts("t2", 3);
    check_copy("t2", 32'h400, 32'h800, 40);

    // Source crosses a 4KB page
    start_cmd(32'hFF8, 32'h2000, 16'd8);
    wait_done("t3");
    repeat (3) @(negedge clk);
    exp_ar = '{32'hFF8, 32'h1000, 32'h0, 32'h0}; exp_aw = '{32'h2000, 32'h2008, 32'h0, 32'h0};
    exp_len = '{1, 5, 0, 0};
    check_bursts("t3", 2);
    check_copy("t3", 32'hFF8, 32'h2000, 8);

    // Random stalls on every slave-driven handshake signal
    bp_en = 1'b1;
    start_cmd(32'h1800, 32'h1C00, 16'd20);
    wait_done("t4");
    repeat (3) @(negedge clk);
    bp_en = 1'b0;
    exp_ar = '{32'h1800, 32'h1840, 32'h0, 32'h0}; exp_aw = '{32'h1C00, 32'h1C40, 32'h0, 32'h0};
    exp_len = '{15, 3, 0, 0};
    check_bursts("t4", 2);
    check_copy("t4", 32'h1800, 32'h1C00, 20);

    // Zero-length command
    start_cmd(32'h010, 32'h600, 16'd0);
    check("t5_done_next", 32'(done), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t5_done_once", 32'(done), 32'd0);
    repeat (4) @(negedge clk);
    check("t5_ar_cnt", 32'(ar_log_addr.size()), 32'd0);
    check("t5_aw_cnt", 32'(aw_log_addr.size()), 32'd0);

    // Reset while writing, then a fresh 2-beat copy
    start_cmd(32'h000, 32'h300, 16'd8);
    begin
      int cyc = 0;
      while (!axi.WVALID && cyc < 500) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("t6_in_wr_data", 32'(axi.WVALID), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_arvalid", 32'(axi.ARVALID), 32'd0);
    check("t6_awvalid", 32'(axi.AWVALID), 32'd0);
    check("t6_wvalid", 32'(axi.WVALID), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_cmd(32'h040, 32'h500, 16'd2);
    wait_done("t6b");
    repeat (3) @(negedge clk);
    exp_ar = '{32'h040, 32'h0, 32'h0, 32'h0}; exp_aw = '{32'h500, 32'h0, 32'h0, 32'h0};
    exp_len = '{1, 0, 0, 0};
    check_bursts("t6b", 1);
    check_copy("t6b", 32'h040, 32'h500, 2);

`ifdef AXI_DMA_RESP_CHECK_EN
    // SLVERR on the first of three write responses
    bresp_err_idx = 0;
    start_cmd(32'h000, 32'hC00, 16'd40);
    wait_done("t7");
    check("t7_err", 32'(err), 32'd1);
    repeat (5) @(negedge clk);
    bresp_err_idx = -1;
    check("t7_ar_cnt", 32'(ar_log_addr.size()), 32'd1);
    check("t7_b_cnt", 32'(b_cnt), 32'd1);
    check("t7_done_cnt", 32'(done_cnt), 32'd1);
    check("t7_err_sticky", 32'(err), 32'd1);
    start_cmd(32'h000, 32'h000, 16'd0);
    check("t7_err_cleared", 32'(err), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
